// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter that lends the single OLED SPI byte engine to NREQ sequencers, one burst at a time.
// Optional macro OLED_ARB_TIMEOUT_EN adds an engine-busy watchdog that abandons a stuck burst.
module oled_spi_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [8*NREQ-1:0] src_data,
  input  logic [NREQ-1:0]   src_dc,
  input  logic [NREQ-1:0]   src_last,
  output logic [NREQ-1:0]   src_ack,
  output logic              eng_start,
  output logic [7:0]        eng_data,
  output logic              eng_dc,
  input  logic              eng_ready,
  output logic              busy,
  output logic [IDW-1:0]    cur_id,
  output logic              timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT, S_RELEASE} state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] src_ack_q;
  logic [IDW-1:0]  cur_id_q;
  logic [IDW-1:0]  last_id_q;
  logic            eng_start_q;
  logic [7:0]      eng_data_q;
  logic            eng_dc_q;
  logic            last_r_q;

  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic [NREQ-1:0] pick_oh;
  logic            g_req;
  logic            g_valid;
  logic            g_dc;
  logic            g_last;
  logic [7:0]      g_data;

  // Two passes: requesters after last_id first, then wrap around to 0..last_id.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req[i] && (i > int'(last_id_q))) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req[i] && (i <= int'(last_id_q))) begin
        pick_found = 1'b1;
        pick_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      pick_oh[i] = pick_found && (IDW'(i) == pick_id);
    end
  end

  always_comb begin
    g_req   = |(req & grant_q);
    g_valid = |(src_valid & grant_q);
    g_dc    = |(src_dc & grant_q);
    g_last  = |(src_last & grant_q);
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) g_data = g_data | src_data[i*8 +: 8];
    end
  end

`ifdef OLED_ARB_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        timeout_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      src_ack_q   <= '0;
      cur_id_q    <= '0;
      last_id_q   <= IDW'(NREQ - 1);
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
      eng_dc_q    <= 1'b0;
      last_r_q    <= 1'b0;
`ifdef OLED_ARB_TIMEOUT_EN
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      eng_start_q <= 1'b0;
      src_ack_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q  <= pick_oh;
            cur_id_q <= pick_id;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!g_req) begin
            state_q <= S_RELEASE;
          end else if (g_valid && eng_ready) begin
            eng_data_q  <= g_data;
            eng_dc_q    <= g_dc;
            last_r_q    <= g_last;
            eng_start_q <= 1'b1;
            src_ack_q   <= grant_q;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          // The engine may still report ready in the cycle right after start.
`ifdef OLED_ARB_TIMEOUT_EN
          tmo_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_ready) begin
            state_q <= (last_r_q || !g_req) ? S_RELEASE : S_ISSUE;
          end
`ifdef OLED_ARB_TIMEOUT_EN
          else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_RELEASE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        S_RELEASE: begin
          grant_q   <= '0;
          last_id_q <= cur_id_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign src_ack   = src_ack_q;
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;
  assign eng_dc    = eng_dc_q;
  assign cur_id    = cur_id_q;
  assign busy      = (state_q != S_IDLE);
`ifdef OLED_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed bench for oled_spi_arbiter: byte-table sequencers and a fixed-latency engine model.
// Define OLED_ARB_TIMEOUT_EN for both files to exercise the watchdog case.
module tb_oled_spi_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  grant;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_data = '0;
  logic [3:0]  src_dc = '0;
  logic [3:0]  src_last = '0;
  logic [3:0]  src_ack;
  logic        eng_start;
  logic [7:0]  eng_data;
  logic        eng_dc;
  logic        eng_ready = 1'b1;
  logic        busy;
  logic [1:0]  cur_id;
  logic        timeout_err;

  always #5 clk = ~clk;

  oled_spi_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .src_valid(src_valid), .src_data(src_data), .src_dc(src_dc),
    .src_last(src_last), .src_ack(src_ack), .eng_start(eng_start),
    .eng_data(eng_data), .eng_dc(eng_dc), .eng_ready(eng_ready),
    .busy(busy), .cur_id(cur_id), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sequencer model: byte tables, burst length, ack count at which req drops (0 = never).
  logic [7:0] tab [4][5];
  logic [4:0] dcm [4];
  int         len [4];
  int         drop_at [4];
  int         acks [4];
  logic [3:0] junk;
  // Engine model and start log
  int         eng_lat;
  int         eng_cnt;
  bit         stuck;
  bit         stick_after;
  logic [7:0] log_data [$];
  logic       log_dc [$];
  logic [1:0] log_id [$];
  int         gaps;
  int         multi_grant;

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = acks[i] % len[i];
      src_valid[i]        = req[i] | junk[i];
      src_data[i*8 +: 8]  = junk[i] ? 8'hEE : tab[i][idx];
      src_dc[i]           = dcm[i][idx];
      src_last[i]         = (idx == len[i] - 1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (eng_start) begin
      log_data.push_back(eng_data);
      log_dc.push_back(eng_dc);
      log_id.push_back(cur_id);
      $display("start id=%0d data=0x%02h dc=%0b", cur_id, eng_data, eng_dc);
      eng_cnt = eng_lat;
      if (stick_after) stuck = 1'b1;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
    end
    eng_ready = !stuck && (eng_cnt == 0);
    for (int i = 0; i < 4; i++) begin
      if (src_ack[i]) begin
        acks[i]++;
        if (acks[i] == drop_at[i]) req[i] = 1'b0;
      end
    end
    if (!busy && grant == 4'b0 && req != 4'b0) gaps++;
    if ($countones(grant) > 1) multi_grant++;
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    junk = '0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 1; drop_at[i] = 0; acks[i] = 0; dcm[i] = '0;
      for (int j = 0; j < 5; j++) tab[i][j] = '0;
    end
    stuck = 1'b0; stick_after = 1'b0; eng_lat = 4; eng_cnt = 0; eng_ready = 1'b1;
    log_data.delete(); log_dc.delete(); log_id.delete();
    drive_src();
    cyc();
    cyc();
    rst = 1'b0;
    gaps = 0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((busy || req != 4'b0) && n < bound) begin
      cyc();
      n++;
    end
    check_eq(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    multi_grant = 0;
    // Reset values and a 3-byte burst from requester 0
    do_reset();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cur_id", cur_id, 0);
    check_eq("rst_start", eng_start, 0);
    check_eq("rst_ack", src_ack, 0);
    check_eq("rst_data", eng_data, 0);
    check_eq("rst_dc", eng_dc, 0);
    check_eq("rst_tmo", timeout_err, 0);
    tab[0][0] = 8'hAE; tab[0][1] = 8'h81; tab[0][2] = 8'h7F;
    len[0] = 3; drop_at[0] = 3;
    req = 4'b0001; drive_src();
    cyc();
    check_eq("t1_grant", grant, 4'b0001);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_cur_id", cur_id, 0);
    cyc();
    check_eq("t1_start", eng_start, 1);
    check_eq("t1_data0", eng_data, 8'hAE);
    check_eq("t1_ack", src_ack, 4'b0001);
    wait_idle("t1_idle", 60);
    check_eq("t1_nstart", log_data.size(), 3);
    check_eq("t1_b1", log_data[1], 8'h81);
    check_eq("t1_b2", log_data[2], 8'h7F);
    check_eq("t1_dc2", log_dc[2], 0);
    check_eq("t1_acks", acks[0], 3);
    check_eq("t1_grant_end", grant, 0);

    // Two requesters, 1-byte bursts, alternating
    do_reset();
    tab[0][0] = 8'h10; tab[2][0] = 8'h20; dcm[2] = 5'b00001;
    drop_at[0] = 2; drop_at[2] = 2;
    req = 4'b0101; drive_src();
    cyc();
    check_eq("t2_grant0", grant, 4'b0001);
    wait_idle("t2_idle", 120);
    check_eq("t2_nstart", log_id.size(), 4);
    check_eq("t2_id0", log_id[0], 0);
    check_eq("t2_id1", log_id[1], 2);
    check_eq("t2_id2", log_id[2], 0);
    check_eq("t2_id3", log_id[3], 2);
    check_eq("t2_dc1", log_dc[1], 1);
    check_eq("t2_data1", log_data[1], 8'h20);
    check_eq("t2_gaps", gaps, 3);

    // Requester 1 drops req after its 2nd of 5 bytes; requester 3 shows junk without requesting
    do_reset();
    for (int j = 0; j < 5; j++) tab[1][j] = 8'h31 + 8'(j);
    len[1] = 5; drop_at[1] = 2; junk[3] = 1'b1;
    req = 4'b0010; drive_src();
    cyc();
    check_eq("t3_grant", grant, 4'b0010);
    check_eq("t3_cur_id", cur_id, 1);
    wait_idle("t3_idle", 80);
    check_eq("t3_nstart", log_data.size(), 2);
    check_eq("t3_b1", log_data[1], 8'h32);
    check_eq("t3_grant_end", grant, 0);
    check_eq("t3_cur_id_held", cur_id, 1);

    // Engine not ready at request time
    do_reset();
    stuck = 1'b1; eng_ready = 1'b0;
    tab[0][0] = 8'h55; drop_at[0] = 1;
    req = 4'b0001; drive_src();
    cyc();
    check_eq("t4_grant", grant, 4'b0001);
    repeat (5) cyc();
    check_eq("t4_nostart", log_data.size(), 0);
    stuck = 1'b0; eng_ready = 1'b1;
    cyc();
    check_eq("t4_start", eng_start, 1);
    wait_idle("t4_idle", 40);
    check_eq("t4_nstart", log_data.size(), 1);

    // Reset during WAIT while the engine is still busy
    do_reset();
    eng_lat = 12;
    tab[0][0] = 8'h01; tab[0][1] = 8'h02; tab[0][2] = 8'h03;
    len[0] = 3; drop_at[0] = 3;
    req = 4'b0001; drive_src();
    repeat (4) cyc();
    rst = 1'b1; req = '0; drive_src();
    cyc();
    check_eq("t5_grant", grant, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_cur_id", cur_id, 0);
    check_eq("t5_start", eng_start, 0);
    check_eq("t5_data", eng_data, 0);
    rst = 1'b0;
    tab[3][0] = 8'h44; drop_at[3] = 1;
    req = 4'b1000; drive_src();
    cyc();
    check_eq("t5_grant3", grant, 4'b1000);
    check_eq("t5_cur_id3", cur_id, 3);
    cyc();
    check_eq("t5_wait_eng", eng_start, 0);
    wait_idle("t5_idle", 60);
    check_eq("t5_nstart", log_data.size(), 2);
    check_eq("t5_data3", log_data[1], 8'h44);
    check_eq("t5_id3", log_id[1], 3);

`ifdef OLED_ARB_TIMEOUT_EN
    // Engine sticks after the first start; watchdog releases and serves requester 1
    do_reset();
    begin
      int n;
      stick_after = 1'b1;
      tab[0][0] = 8'hA0; tab[0][1] = 8'hA1; len[0] = 2;
      tab[1][0] = 8'hB0; drop_at[1] = 1;
      req = 4'b0011; drive_src();
      cyc();
      cyc();
      check_eq("t6_start", eng_start, 1);
      n = 0;
      while (!timeout_err && n < 40) begin
        cyc();
        n++;
      end
      check_eq("t6_tmo_cycles", n, 17);
      check_eq("t6_tmo", timeout_err, 1);
      stick_after = 1'b0; stuck = 1'b0; eng_ready = 1'b1; eng_cnt = 0;
      req[0] = 1'b0; drive_src();
      cyc();
      check_eq("t6_grant_clr", grant, 0);
      cyc();
      check_eq("t6_next", grant, 4'b0010);
      wait_idle("t6_idle", 60);
      check_eq("t6_data", log_data[log_data.size()-1], 8'hB0);
      check_eq("t6_sticky", timeout_err, 1);
    end
    do_reset();
    check_eq("t6_rst_clr", timeout_err, 0);
`else
    check_eq("tmo_tied", timeout_err, 0);
`endif

    check_eq("onehot", multi_grant, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
